calc_arbiter: RTL

- Shares one Small_Calculator datapath between two requesters, A and B, using round-robin arbitration.
- For the winner it latches the operation and operands, pulses the calculator's Go, and waits for Done. It then returns the result to the owning requester.
- A watchdog aborts a hung operation.
- Sits between the requester logic and the calculator, in the same clock domain as the calculator.

---
 rtl/calc_arbiter.sv | 131 +++++++++++++
 1 files changed

// File: rtl/calc_arbiter.sv
// calc_arbiter: round-robin sharing of one calculator between requesters A and B,
// with registered outputs and a watchdog that aborts a hung operation.
module calc_arbiter #(
   parameter int W       = 3,
   parameter int TIMEOUT = 255,
   parameter int TW      = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         a_req,
   input  logic [1:0]   a_op,
   input  logic [W-1:0] a_in1,
   input  logic [W-1:0] a_in2,
   output logic         a_gnt,
   output logic         a_done,
   output logic [W-1:0] a_res,
   input  logic         b_req,
   input  logic [1:0]   b_op,
   input  logic [W-1:0] b_in1,
   input  logic [W-1:0] b_in2,
   output logic         b_gnt,
   output logic         b_done,
   output logic [W-1:0] b_res,
   output logic         calc_go,
   output logic [1:0]   calc_op,
   output logic [W-1:0] calc_in1,
   output logic [W-1:0] calc_in2,
   input  logic         calc_done,
   input  logic [W-1:0] calc_out,
   output logic         busy,
   output logic         owner,
   output logic         timeout_err
);
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
   state_t state, state_n;
   logic ptr, ptr_n, sel_b;
   logic [TW-1:0] wd, wd_n;
   logic a_gnt_n, b_gnt_n, a_done_n, b_done_n, calc_go_n, owner_n, timeout_err_n;
   logic [1:0] calc_op_n;
   logic [W-1:0] a_res_n, b_res_n, calc_in1_n, calc_in2_n, res_v;

   assign sel_b = b_req & (~a_req | ptr);
   // a watchdog abort reports a zero result
   assign res_v = calc_done ? calc_out : '0;

   always_comb begin
      state_n       = state;
      ptr_n         = ptr;
      wd_n          = wd;
      a_gnt_n       = 1'b0;
      b_gnt_n       = 1'b0;
      a_done_n      = 1'b0;
      b_done_n      = 1'b0;
      calc_go_n     = 1'b0;
      a_res_n       = a_res;
      b_res_n       = b_res;
      calc_op_n     = calc_op;
      calc_in1_n    = calc_in1;
      calc_in2_n    = calc_in2;
      owner_n       = owner;
      timeout_err_n = timeout_err;
      case (state)
         IDLE: if (a_req | b_req) begin
            state_n    = ISSUE;
            owner_n    = sel_b;
            a_gnt_n    = ~sel_b;
            b_gnt_n    = sel_b;
            calc_op_n  = sel_b ? b_op : a_op;
            calc_in1_n = sel_b ? b_in1 : a_in1;
            calc_in2_n = sel_b ? b_in2 : a_in2;
         end
         ISSUE: begin
            state_n   = WAIT;
            calc_go_n = 1'b1;
            wd_n      = '0;
         end
         WAIT: begin
            wd_n = wd + 1'b1;
            if (calc_done || wd_n == TW'(TIMEOUT)) begin
               state_n       = RESP;
               ptr_n         = ~owner;
               a_done_n      = ~owner;
               b_done_n      = owner;
               timeout_err_n = timeout_err | ~calc_done;
               a_res_n       = owner ? a_res : res_v;
               b_res_n       = owner ? res_v : b_res;
            end
         end
         // linger while Done is still high so it cannot leak into the next transaction
         default: state_n = calc_done ? RESP : IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         ptr         <= 1'b0;
         wd          <= '0;
         a_gnt       <= 1'b0;
         b_gnt       <= 1'b0;
         a_done      <= 1'b0;
         b_done      <= 1'b0;
         a_res       <= '0;
         b_res       <= '0;
         calc_go     <= 1'b0;
         calc_op     <= '0;
         calc_in1    <= '0;
         calc_in2    <= '0;
         busy        <= 1'b0;
         owner       <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         state       <= state_n;
         ptr         <= ptr_n;
         wd          <= wd_n;
         a_gnt       <= a_gnt_n;
         b_gnt       <= b_gnt_n;
         a_done      <= a_done_n;
         b_done      <= b_done_n;
         a_res       <= a_res_n;
         b_res       <= b_res_n;
         calc_go     <= calc_go_n;
         calc_op     <= calc_op_n;
         calc_in1    <= calc_in1_n;
         calc_in2    <= calc_in2_n;
         busy        <= state_n != IDLE;
         owner       <= owner_n;
         timeout_err <= timeout_err_n;
      end
   end
endmodule
